// File: rtl/mem_arbiter.sv
// Arbitrates one slow_memory line port between the I-cache and D-cache.
// Whole transactions are granted; D has priority, bounded by a starvation limit on I.
module mem_arbiter #(
   parameter int MAX_CONSEC = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_read_I,
   input  logic             mem_write_I,
   input  logic [27:0]      mem_addr_I,
   input  logic [127:0]     mem_wdata_I,
   output logic [127:0]     mem_rdata_I,
   output logic             mem_ready_I,
   input  logic             mem_read_D,
   input  logic             mem_write_D,
   input  logic [27:0]      mem_addr_D,
   input  logic [127:0]     mem_wdata_D,
   output logic [127:0]     mem_rdata_D,
   output logic             mem_ready_D,
   output logic             mem_read,
   output logic             mem_write,
   output logic [27:0]      mem_addr,
   output logic [127:0]     mem_wdata,
   input  logic [127:0]     mem_rdata,
   input  logic             mem_ready,
   output logic             busy,
   output logic             owner,
   output logic [CNT_W-1:0] grant_cnt_I,
   output logic [CNT_W-1:0] grant_cnt_D
);

   localparam int CONS_W = $clog2(MAX_CONSEC + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t              state;
   logic [CONS_W-1:0]   consec_d;
   logic                req_i;
   logic                req_d;
   logic                grant_d;
   logic                grant_i;

   always_comb begin
      req_i   = mem_read_I | mem_write_I;
      req_d   = mem_read_D | mem_write_D;
      grant_d = req_d & (~req_i | (consec_d < CONS_W'(MAX_CONSEC)));
      grant_i = req_i & ~grant_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_rdata_I <= '0;
         mem_rdata_D <= '0;
         mem_ready_I <= 1'b0;
         mem_ready_D <= 1'b0;
         busy        <= 1'b0;
         owner       <= 1'b0;
         grant_cnt_I <= '0;
         grant_cnt_D <= '0;
         consec_d    <= '0;
      end else begin
         case (state)
            IDLE: begin
               // A simultaneous read+write request is forwarded as a write only.
               if (grant_d) begin
                  mem_addr  <= mem_addr_D;
                  mem_wdata <= mem_wdata_D;
                  mem_write <= mem_write_D;
                  mem_read  <= mem_read_D & ~mem_write_D;
                  owner     <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ACCESS;
                  if (req_i) begin
                     if (consec_d != CONS_W'(MAX_CONSEC))
                        consec_d <= consec_d + 1'b1;
                  end else begin
                     consec_d <= '0;
                  end
               end else if (grant_i) begin
                  mem_addr  <= mem_addr_I;
                  mem_wdata <= mem_wdata_I;
                  mem_write <= mem_write_I;
                  mem_read  <= mem_read_I & ~mem_write_I;
                  owner     <= 1'b0;
                  busy      <= 1'b1;
                  state     <= ACCESS;
                  consec_d  <= '0;
               end
            end
            ACCESS: begin
               if (mem_ready) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  state     <= DONE;
                  if (owner) begin
                     mem_ready_D <= 1'b1;
                     if (mem_read)
                        mem_rdata_D <= mem_rdata;
                     if (grant_cnt_D != '1)
                        grant_cnt_D <= grant_cnt_D + 1'b1;
                  end else begin
                     mem_ready_I <= 1'b1;
                     if (mem_read)
                        mem_rdata_I <= mem_rdata;
                     if (grant_cnt_I != '1)
                        grant_cnt_I <= grant_cnt_I + 1'b1;
                  end
               end
            end
            DONE: begin
               mem_ready_I <= 1'b0;
               mem_ready_D <= 1'b0;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester drivers, a latency memory model,
// and a monitor that pops expected grants/completions as the DUT produces them.
module tb_mem_arbiter;

   localparam int CW  = 4;
   localparam int LAT = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           mem_read_I, mem_write_I, mem_read_D, mem_write_D;
   logic [27:0]    mem_addr_I, mem_addr_D, mem_addr;
   logic [127:0]   mem_wdata_I, mem_wdata_D, mem_wdata;
   logic [127:0]   mem_rdata_I, mem_rdata_D, mem_rdata;
   logic           mem_ready_I, mem_ready_D;
   logic           mem_read, mem_write, mem_ready;
   logic           mem_ready_m, mem_ready_x;
   logic           busy, owner;
   logic [CW-1:0]  grant_cnt_I, grant_cnt_D;

   assign mem_ready = mem_ready_m | mem_ready_x;

   always #5 clk = ~clk;

   mem_arbiter #(.MAX_CONSEC(4), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .mem_read_I(mem_read_I), .mem_write_I(mem_write_I), .mem_addr_I(mem_addr_I),
      .mem_wdata_I(mem_wdata_I), .mem_rdata_I(mem_rdata_I), .mem_ready_I(mem_ready_I),
      .mem_read_D(mem_read_D), .mem_write_D(mem_write_D), .mem_addr_D(mem_addr_D),
      .mem_wdata_D(mem_wdata_D), .mem_rdata_D(mem_rdata_D), .mem_ready_D(mem_ready_D),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .busy(busy), .owner(owner), .grant_cnt_I(grant_cnt_I), .grant_cnt_D(grant_cnt_D)
   );

   typedef struct {
      logic          rd;
      logic          wr;
      logic [27:0]   addr;
      logic [127:0]  wdata;
   } req_t;

   typedef struct {
      logic          owner;
      logic          rd;
      logic          wr;
      logic [27:0]   addr;
      logic [127:0]  wdata;
   } grant_t;

   typedef struct {
      logic          owner;
      logic [127:0]  rdata;
      logic [CW-1:0] cnt;
   } cpl_t;

   req_t    q_i[$];
   req_t    q_d[$];
   grant_t  exp_g[$];
   cpl_t    exp_c[$];

   int            compared   = 0;
   int            mismatched = 0;
   logic          flush_i    = 1'b0;
   logic          mem_auto   = 1'b1;
   logic [CW-1:0] m_cnt_i, m_cnt_d;
   logic [127:0]  m_rd_i, m_rd_d;

   function automatic logic [127:0] line_of(input logic [27:0] a);
      return {a, 4'h1, a, 4'h2, a, 4'h3, a, 4'h4};
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input bit port, input logic rd, input logic wr,
                        input logic [27:0] a, input logic [127:0] wd);
      req_t r;
      r.rd = rd; r.wr = wr; r.addr = a; r.wdata = wd;
      if (port) q_d.push_back(r);
      else      q_i.push_back(r);
   endtask

   // Expected grant in arbitration order; completion data derived from the bench's own line model.
   task automatic expect_txn(input bit port, input logic rd, input logic wr,
                             input logic [27:0] a, input logic [127:0] wd, input bit completes);
      grant_t g;
      cpl_t   c;
      g.owner = port; g.rd = rd & ~wr; g.wr = wr; g.addr = a; g.wdata = wd;
      exp_g.push_back(g);
      if (completes) begin
         c.owner = port;
         if (port) begin
            if (rd && !wr) m_rd_d = line_of(a);
            if (m_cnt_d != '1) m_cnt_d++;
            c.rdata = m_rd_d; c.cnt = m_cnt_d;
         end else begin
            if (rd && !wr) m_rd_i = line_of(a);
            if (m_cnt_i != '1) m_cnt_i++;
            c.rdata = m_rd_i; c.cnt = m_cnt_i;
         end
         exp_c.push_back(c);
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while ((exp_g.size() != 0 || exp_c.size() != 0 || q_i.size() != 0 ||
              q_d.size() != 0 || busy) && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check(tag, (k < 2000), 1'b1);
   endtask

   initial begin
      rst = 1'b1;
      mem_read_I = 1'b0; mem_write_I = 1'b0; mem_addr_I = '0; mem_wdata_I = '0;
      mem_read_D = 1'b0; mem_write_D = 1'b0; mem_addr_D = '0; mem_wdata_D = '0;
      mem_rdata = '0; mem_ready_m = 1'b0; mem_ready_x = 1'b0;
      m_cnt_i = '0; m_cnt_d = '0; m_rd_i = '0; m_rd_d = '0;

      fork
         begin : main_seq
            logic [127:0] wd;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            check("rst_outputs", {busy, owner, mem_read, mem_write, mem_addr, mem_wdata,
                                  mem_ready_I, mem_ready_D}, '0);
            check("rst_rdata", {mem_rdata_I, mem_rdata_D}, '0);
            check("rst_cnt", {grant_cnt_I, grant_cnt_D}, '0);

            // I read alone: command one cycle after the request is visible.
            sync();
            issue(0, 1, 0, 28'h0000010, '0);
            expect_txn(0, 1, 0, 28'h0000010, '0, 1);
            for (int k = 0; k < 50 && mem_read_I !== 1'b1; k++) sync();
            sync();
            check("t1_cmd_latency", {mem_read, mem_write, busy, owner}, 4'b1010);
            wait_idle("t1_done");
            check("t1_cnt", {grant_cnt_I, grant_cnt_D}, {4'd1, 4'd0});
            check("t1_d_quiet", mem_rdata_D, '0);

            // D write and I read together: D first, I sampled in r+2.
            sync();
            issue(1, 0, 1, 28'h00000A0, 128'hD00D_0000_1111_2222_3333_4444_5555_6666);
            issue(0, 1, 0, 28'h00000B0, '0);
            expect_txn(1, 0, 1, 28'h00000A0, 128'hD00D_0000_1111_2222_3333_4444_5555_6666, 1);
            expect_txn(0, 1, 0, 28'h00000B0, '0, 1);
            for (int k = 0; k < 100 && mem_ready_D !== 1'b1; k++) @(negedge clk);
            check("t2_ready_D_seen", mem_ready_D, 1'b1);
            check("t2_busy_r1", busy, 1'b1);
            @(negedge clk);
            check("t2_busy_r2", busy, 1'b0);
            @(negedge clk);
            check("t2_grant_I_r3", {busy, owner, mem_read}, 3'b101);
            wait_idle("t2_done");

            // Starvation limit: D,D,D,D,I,D,D,I with I always waiting.
            sync();
            for (int k = 0; k < 6; k++) begin
               wd = {32'hDA7A_0000, 96'(k)};
               issue(1, (k % 2 == 0), (k % 2 == 1), 28'(32'h100 + k), wd);
            end
            issue(0, 1, 0, 28'h0000180, '0);
            issue(0, 1, 0, 28'h0000190, '0);
            for (int k = 0; k < 4; k++) begin
               wd = {32'hDA7A_0000, 96'(k)};
               expect_txn(1, (k % 2 == 0), (k % 2 == 1), 28'(32'h100 + k), wd, 1);
            end
            expect_txn(0, 1, 0, 28'h0000180, '0, 1);
            for (int k = 4; k < 6; k++) begin
               wd = {32'hDA7A_0000, 96'(k)};
               expect_txn(1, (k % 2 == 0), (k % 2 == 1), 28'(32'h100 + k), wd, 1);
            end
            expect_txn(0, 1, 0, 28'h0000190, '0, 1);
            wait_idle("t3_done");

            // Read and write both high: forwarded as write, read data untouched.
            sync();
            issue(0, 1, 1, 28'h0000020, 128'hC0FFEE);
            expect_txn(0, 1, 1, 28'h0000020, 128'hC0FFEE, 1);
            wait_idle("t4_done");
            check("t4_rdata_I_kept", mem_rdata_I, line_of(28'h0000190));

            // Reset while in ACCESS, then a late mem_ready.
            mem_auto = 1'b0;
            sync();
            issue(0, 1, 0, 28'h0000030, '0);
            expect_txn(0, 1, 0, 28'h0000030, '0, 0);
            for (int k = 0; k < 50 && busy !== 1'b1; k++) @(negedge clk);
            check("t5_in_access", {busy, mem_read}, 2'b11);
            sync();
            rst = 1'b1;
            flush_i = 1'b1;
            sync();
            rst = 1'b0;
            flush_i = 1'b0;
            m_cnt_i = '0; m_cnt_d = '0; m_rd_i = '0; m_rd_d = '0;
            @(negedge clk);
            check("t5_rst_outputs", {busy, owner, mem_read, mem_write, mem_addr, mem_wdata,
                                     mem_ready_I, mem_ready_D}, '0);
            check("t5_rst_rdata", {mem_rdata_I, mem_rdata_D}, '0);
            check("t5_rst_cnt", {grant_cnt_I, grant_cnt_D}, '0);
            mem_ready_x = 1'b1;
            @(negedge clk);
            mem_ready_x = 1'b0;
            for (int k = 0; k < 4; k++) begin
               check("t5_no_ready", {mem_ready_I, mem_ready_D, busy}, 3'b000);
               @(negedge clk);
            end
            mem_auto = 1'b1;

            // Saturation of the 4-bit D counter after 17 completions.
            sync();
            for (int k = 0; k < 17; k++) begin
               issue(1, 1, 0, 28'(32'h200 + k), '0);
               expect_txn(1, 1, 0, 28'(32'h200 + k), '0, 1);
            end
            wait_idle("t6_done");
            check("t6_sat", grant_cnt_D, 4'hF);
            check("t6_cnt_I", grant_cnt_I, 4'd0);
         end

         begin : drv_i
            bit   act;
            req_t r;
            act = 0;
            forever begin
               @(negedge clk);
               if (flush_i) begin
                  mem_read_I = 1'b0; mem_write_I = 1'b0; act = 0;
                  q_i.delete();
               end else begin
                  if (act && mem_ready_I) begin
                     act = 0; mem_read_I = 1'b0; mem_write_I = 1'b0;
                  end
                  if (!act && q_i.size() > 0) begin
                     r = q_i.pop_front();
                     mem_read_I = r.rd; mem_write_I = r.wr;
                     mem_addr_I = r.addr; mem_wdata_I = r.wdata;
                     act = 1;
                  end
               end
            end
         end

         begin : drv_d
            bit   act;
            req_t r;
            act = 0;
            forever begin
               @(negedge clk);
               if (act && mem_ready_D) begin
                  act = 0; mem_read_D = 1'b0; mem_write_D = 1'b0;
               end
               if (!act && q_d.size() > 0) begin
                  r = q_d.pop_front();
                  mem_read_D = r.rd; mem_write_D = r.wr;
                  mem_addr_D = r.addr; mem_wdata_D = r.wdata;
                  act = 1;
               end
            end
         end

         begin : mem_model
            int mc;
            bit seen;
            mc = 0;
            seen = 0;
            forever begin
               @(negedge clk);
               mem_ready_m = 1'b0;
               if (mem_auto) begin
                  if (mc > 0) begin
                     mc--;
                     if (mc == 0) begin
                        mem_ready_m = 1'b1;
                        mem_rdata = line_of(mem_addr);
                     end
                  end else if ((mem_read || mem_write) && !seen) begin
                     mc = LAT;
                     seen = 1;
                  end
               end
               if (!(mem_read || mem_write)) seen = 0;
            end
         end

         begin : monitor
            logic   pb;
            grant_t g;
            cpl_t   c;
            pb = 1'b0;
            forever begin
               @(negedge clk);
               if (busy && !pb) begin
                  if (exp_g.size() == 0) begin
                     check("unexpected_grant", busy, 1'b0);
                  end else begin
                     g = exp_g.pop_front();
                     check("grant", {owner, mem_read, mem_write, mem_addr, mem_wdata},
                           {g.owner, g.rd, g.wr, g.addr, g.wdata});
                  end
               end
               pb = busy;
               if (mem_ready_I || mem_ready_D) begin
                  if (exp_c.size() == 0) begin
                     check("unexpected_ready", {mem_ready_I, mem_ready_D}, 2'b00);
                  end else begin
                     c = exp_c.pop_front();
                     check("ready_sel", {mem_ready_I, mem_ready_D}, c.owner ? 2'b01 : 2'b10);
                     check("rdata", c.owner ? mem_rdata_D : mem_rdata_I, c.rdata);
                     check("grant_cnt", c.owner ? grant_cnt_D : grant_cnt_I, c.cnt);
                  end
               end
            end
         end

         begin : watchdog
            repeat (50000) @(posedge clk);
            compared++;
            mismatched++;
            $display("FAIL watchdog: observed timeout expected completion");
         end
      join_any
      disable fork;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one slow_memory port (128-bit line, address [31:4]) between the I-cache and the D-cache refill/write-back interfaces inside CHIP.
- Lets a single-memory configuration use the existing cache memory handshakes unchanged.
- Grants whole transactions (request → mem_ready) and never interleaves two of them.
- Uses fixed D priority with a starvation limit, and provides grant statistics.

Parameters:
- MAX_CONSEC, 4: maximum number of back-to-back D grants while I is waiting; the next grant is then forced to I.
- CNT_W, 16: width of the saturating grant counters.

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- mem_read_I  in  1  I-cache read request (level, held until mem_ready_I)
- mem_write_I  in  1  I-cache write request (level)
- mem_addr_I  in  28  I line address [31:4]
- mem_wdata_I  in  128  I write data
- mem_rdata_I  out  128  read data returned to I
- mem_ready_I  out  1  one-cycle completion pulse to I
- mem_read_D, mem_write_D, mem_addr_D, mem_wdata_D, mem_rdata_D, mem_ready_D: same as the I ports, for the D-cache
- mem_read  out  1  to slow memory
- mem_write  out  1  to slow memory
- mem_addr  out  28  to slow memory
- mem_wdata  out  128  to slow memory
- mem_rdata  in  128  from slow memory
- mem_ready  in  1  from slow memory, one-cycle pulse
- busy  out  1  high while a transaction is owned
- owner  out  1  0 = I, 1 = D; valid while busy
- grant_cnt_I  out  CNT_W  completed I transactions, saturating
- grant_cnt_D  out  CNT_W  completed D transactions, saturating

Behaviour:
- Reset (rst = 1 at a posedge):
  - state goes to IDLE.
  - All outputs go to 0: mem_read/mem_write, mem_addr, mem_wdata, mem_rdata_X, mem_ready_X, busy, owner, counters, consecutive-D counter.
  - Any in-flight memory access is abandoned. A reset mid-transaction takes effect on the next edge regardless of mem_ready.
- Request decoding: reqX = mem_read_X | mem_write_X.
  - If both read and write are high, it is treated as a write; only mem_write is forwarded.
- FSM states: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - Grant D if reqD and (!reqI or consec_D < MAX_CONSEC).
  - Otherwise grant I if reqI.
  - On grant, at the next edge:
    - latch addr, wdata and read/write of the winner into the memory outputs;
    - set owner and busy = 1;
    - go to ACCESS.
  - Latency: request visible in cycle t → memory command asserted in cycle t+1.
- ACCESS:
  - Memory outputs are held stable.
  - Requester inputs are ignored, so changes on them have no effect.
  - When mem_ready = 1 in cycle r, at the next edge:
    - drop mem_read/mem_write;
    - register mem_rdata into the owner's mem_rdata_X (reads only; writes leave it unchanged);
    - pulse the owner's mem_ready_X for exactly cycle r+1;
    - increment that owner's grant counter (saturate at all-ones);
    - go to DONE.
- DONE (cycle r+1):
  - busy stays 1.
  - The requester drops its request at the end of r+1.
  - Next edge: go to IDLE, busy = 0, mem_ready_X = 0.
  - The earliest next grant sample is cycle r+2.
- mem_rdata_X holds its value until the next read completion for that port.
- Starvation counter consec_D:
  - increments (saturating at MAX_CONSEC) on each D grant made while reqI = 1;
  - clears on any I grant, and on any D grant made while reqI = 0.
- The non-owner's mem_ready is never asserted.
- mem_ready arriving in IDLE or DONE is ignored.
- No transaction is ever dropped, except by reset.

Test Plan:
- I read only, addr 28'h0000010, memory ready 4 cycles after command:
  - mem_read high from t+1;
  - mem_ready_I pulses once with mem_rdata_I = memory line;
  - grant_cnt_I = 1; D outputs stay 0.
- D write and I read raised in the same cycle:
  - D is granted first (owner = 1, mem_write = 1, mem_wdata = D data);
  - after mem_ready_D, I is granted in cycle r+2.
- I continuously requesting, D issuing 6 back-to-back requests, MAX_CONSEC = 4:
  - grant order D,D,D,D,I,D,D;
  - consec_D clears after the I grant.
- Requester holds both read and write at addr 28'h0000020:
  - only mem_write is asserted downstream;
  - mem_rdata_X is unchanged after completion.
- rst asserted in ACCESS before mem_ready:
  - next cycle all outputs are 0 and state is IDLE;
  - a late mem_ready produces no mem_ready_I/D pulse.
- grant_cnt_D preloaded near max (CNT_W = 4, 15 completions, then 2 more):
  - grant_cnt_D saturates at 4'hF.
